// File: rtl/basilisk_reg_status_tracker_pkg.sv
// ----------------------------------------------------------------------------
// basilisk_reg_status_tracker_pkg
// Shared types for the Basilisk FP register scoreboard and the decode-stage
// hazard utilities.
//   BASILISK_REG_COUNT           : number of FP architectural registers (32)
//   basilisk_decode_reg_status_t : 2-bit per-register status seen by decode
//   basilisk_reg_status_vector_t : packed [32] vector of the above (64 bits)
//   basilisk_reg_status_encode() : (count, release hit, max) -> status
// ----------------------------------------------------------------------------
package basilisk_reg_status_tracker_pkg;

    localparam int BASILISK_REG_COUNT = 32;

    typedef enum logic [1:0] {
        BASILISK_REG_VALID     = 2'b00,
        BASILISK_REG_INVALID   = 2'b01,
        BASILISK_REG_SLIDEUP   = 2'b10,
        BASILISK_REG_SLIDEDOWN = 2'b11
    } basilisk_decode_reg_status_t;

    typedef basilisk_decode_reg_status_t [BASILISK_REG_COUNT-1:0] basilisk_reg_status_vector_t;

    // Counts are passed zero-extended to 8 bits so the same helper serves
    // any counter width up to 8.
    function automatic basilisk_decode_reg_status_t basilisk_reg_status_encode(
        input logic [7:0] cnt,
        input logic       release_hit,
        input logic [7:0] max
    );
        basilisk_decode_reg_status_t st;
        if (cnt == 8'd1 && release_hit) begin
            st = BASILISK_REG_SLIDEUP;
        end else if (cnt == max) begin
            st = BASILISK_REG_SLIDEDOWN;
        end else if (cnt != 8'd0) begin
            st = BASILISK_REG_INVALID;
        end else begin
            st = BASILISK_REG_VALID;
        end
        return st;
    endfunction

endpackage

// File: rtl/basilisk_reg_status_tracker_counter.sv
// ----------------------------------------------------------------------------
// basilisk_reg_status_counter
// One saturating up/down outstanding-write counter for a single FP register.
//   clk, rst_n   : clock, async active-low reset
//   claim_i      : accepted claim targeting this register
//   rel_i        : writeback release targeting this register
//   flush_i      : clear the count on the next edge (beats claim/release)
//   status_o     : decode status for this register
//   full_o       : count at its maximum
//   nonzero_o    : count non-zero
// ----------------------------------------------------------------------------
module basilisk_reg_status_counter
    import basilisk_reg_status_tracker_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        claim_i,
    input  logic                        rel_i,
    input  logic                        flush_i,
    output basilisk_decode_reg_status_t status_o,
    output logic                        full_o,
    output logic                        nonzero_o
);

    localparam logic [PENDING_W-1:0] CNT_MAX = '1;

    logic [PENDING_W-1:0] cnt_q;
    logic [PENDING_W-1:0] cnt_d;

    // Both ends saturate: a release on an empty counter and a claim on a full
    // one (only possible if the producer ignores ready) leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (claim_i && !rel_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!claim_i && rel_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign status_o  = basilisk_reg_status_encode(8'(cnt_q), rel_i, 8'(CNT_MAX));
    assign full_o    = (cnt_q == CNT_MAX);
    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/basilisk_reg_status_tracker.sv
// ----------------------------------------------------------------------------
// basilisk_reg_status_tracker
// Per-register scoreboard of in-flight FP writes feeding decode's hazard check.
//   clk, rst_n       : clock, async active-low reset
//   issue_valid/rd   : decode claims FP rd;  issue_ready : claim accepted
//   wb_valid/wb_rd   : writeback releases one write (no backpressure)
//   flush            : drop all pending claims on the next edge
//   reg_status[63:0] : packed basilisk_decode_reg_status_t [32], entry i at [2i+1:2i]
//   busy             : any register has an outstanding write
//   err              : (only with BASILISK_REG_STATUS_ERROR_CHECK_EN) sticky
//                      protocol-violation flag, cleared only by reset
// Optional build macro: BASILISK_REG_STATUS_ERROR_CHECK_EN
// ----------------------------------------------------------------------------
module basilisk_reg_status_tracker
    import basilisk_reg_status_tracker_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [63:0] reg_status,
    output logic        busy
`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
    ,
    output logic        err
`endif
);

    basilisk_reg_status_vector_t   status_vec;
    logic [BASILISK_REG_COUNT-1:0] full;
    logic [BASILISK_REG_COUNT-1:0] nonzero;
    logic                          wb_hits_issue;
    logic                          claim_fire;

    // A full register can still take a claim when its own release lands in
    // the same cycle, since the net count is unchanged.
    assign wb_hits_issue = wb_valid && (wb_rd == issue_rd);
    assign issue_ready   = !full[issue_rd] || wb_hits_issue;
    assign claim_fire    = issue_valid && issue_ready;

    for (genvar r = 0; r < BASILISK_REG_COUNT; r++) begin : g_cnt
        basilisk_reg_status_counter #(
            .PENDING_W (PENDING_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .claim_i   (claim_fire && (issue_rd == 5'(r))),
            .rel_i     (wb_valid && (wb_rd == 5'(r))),
            .flush_i   (flush),
            .status_o  (status_vec[r]),
            .full_o    (full[r]),
            .nonzero_o (nonzero[r])
        );
    end

    assign reg_status = status_vec;
    assign busy       = |nonzero;

`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
    logic underflow;
    logic overflow;
    logic err_q;
    logic err_d;

    assign underflow = wb_valid && !nonzero[wb_rd];
    // Only reachable when the producer drives valid while ready is low.
    assign overflow  = issue_valid && !issue_ready;
    assign err_d     = err_q || underflow || overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!underflow) else $warning("release on idle FP register %0d", wb_rd);
            assert (!overflow)  else $warning("claim on saturated FP register %0d", issue_rd);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_basilisk_reg_status_tracker.sv
module tb_basilisk_reg_status_tracker;
    import basilisk_reg_status_tracker_pkg::*;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [4:0]  issue_rd = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [63:0] reg_status;
    logic        busy;
    logic        err_w;

    always #5 clk = ~clk;

    basilisk_reg_status_tracker #(.PENDING_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .reg_status  (reg_status),
`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
        .busy        (busy),
        .err         (err_w)
`else
        .busy        (busy)
`endif
    );

`ifndef BASILISK_REG_STATUS_ERROR_CHECK_EN
    assign err_w = 1'b0;
`endif

    typedef struct {
        logic [63:0] st;
        logic        bsy;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain integer counts per register.
    int   m_cnt[32];
    logic m_err = 1'b0;

    function automatic logic [1:0] m_status(input int c, input logic hit);
        if (c == 1 && hit)  return BASILISK_REG_SLIDEUP;
        if (c == MAXC)      return BASILISK_REG_SLIDEDOWN;
        if (c != 0)         return BASILISK_REG_INVALID;
        return BASILISK_REG_VALID;
    endfunction

    function automatic logic m_ready(input logic [4:0] ird, input logic wv, input logic [4:0] wrd);
        return (m_cnt[ird] != MAXC) || (wv && wrd == ird);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err = 1'b0;
    endtask

    // One cycle of stimulus; the expected outputs for this cycle are queued
    // and the model advances to the state after the next edge.
    task automatic drive(input logic iv, input logic [4:0] ird, input logic wv,
                         input logic [4:0] wrd, input logic fl);
        exp_t e;
        logic rdy;
        @(posedge clk);
        #1;
        issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd; flush = fl;
        e.st  = '0;
        e.bsy = 1'b0;
        for (int r = 0; r < 32; r++) begin
            e.st[2*r +: 2] = m_status(m_cnt[r], wv && wrd == 5'(r));
            if (m_cnt[r] != 0) e.bsy = 1'b1;
        end
        rdy   = m_ready(ird, wv, wrd);
        e.rdy = rdy;
        e.err = m_err;
        q.push_back(e);
`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
        if ((iv && !rdy) || (wv && m_cnt[wrd] == 0)) m_err = 1'b1;
`endif
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else if (!(iv && rdy && wv && ird == wrd)) begin
            if (iv && rdy) m_cnt[ird] = m_cnt[ird] + 1;
            if (wv && m_cnt[wrd] > 0) m_cnt[wrd] = m_cnt[wrd] - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("reg_status", reg_status, e.st);
                check("busy", 64'(busy), 64'(e.bsy));
                check("issue_ready", 64'(issue_ready), 64'(e.rdy));
`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
                check("err", 64'(err_w), 64'(e.err));
`endif
            end
        end
    end

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        logic       iv, wv, fl;
        logic [4:0] ird, wrd;
        model_reset();
        #12;
        check("reset_status", reg_status, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_ready", 64'(issue_ready), 64'h1);
        #11;
        rst_n = 1'b1;
        idle(3);

        // claim f5, release two cycles later
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        idle(1);
        drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        idle(1);

        // saturate f7, probe ready, then full-register claim with release
        repeat (3) drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
        idle(1);
        repeat (3) drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        idle(1);

        // same-cycle claim and release on f3 with one outstanding
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b0);
        idle(1);
        drive(1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
        idle(1);

        // flush beats a same-cycle claim
        drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        idle(2);

        // release on idle f9: saturates at 0 (and flags err when built in)
        drive(1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        idle(3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            iv  = 1'($urandom_range(0, 1));
            ird = pick();
            wv  = 1'($urandom_range(0, 1));
            wrd = pick();
            fl  = ($urandom_range(0, 63) == 0);
            if (wv && m_cnt[wrd] == 0 && $urandom_range(0, 3) != 0) wv = 1'b0;
`ifdef BASILISK_REG_STATUS_ERROR_CHECK_EN
            if (wv && m_cnt[wrd] == 0) wv = 1'b0;
            if (iv && !m_ready(ird, wv, wrd)) iv = 1'b0;
`endif
            drive(iv, ird, wv, wrd, fl);
        end

        // asynchronous reset in the middle of activity
        repeat (3) drive(1'b1, 5'd6, 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1;
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; issue_rd = 5'd6;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_status", reg_status, 64'h0);
        check("async_rst_busy", 64'(busy), 64'h0);
        check("async_rst_ready", 64'(issue_ready), 64'h1);
        model_reset();
        #1;
        rst_n = 1'b1;
        idle(3);

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
